// File: rtl/mig7_arbiter_if.sv
// MIG7 DDR3 user-interface bundle between the arbiter (master) and the
// mig7series instance (slave).
interface mig7_arbiter_if #(
    parameter int AW = 28,
    parameter int DW = 128
);
    logic [AW-1:0]   app_addr;
    logic [2:0]      app_cmd;
    logic            app_en;
    logic [DW-1:0]   app_wdf_data;
    logic            app_wdf_end;
    logic [DW/8-1:0] app_wdf_mask;
    logic            app_wdf_wren;
    logic            app_rdy;
    logic            app_wdf_rdy;
    logic [DW-1:0]   app_rd_data;
    logic            app_rd_data_valid;
    logic            app_sr_req;
    logic            app_ref_req;
    logic            app_zq_req;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end,
               app_wdf_mask, app_wdf_wren, app_sr_req, app_ref_req, app_zq_req,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end,
               app_wdf_mask, app_wdf_wren, app_sr_req, app_ref_req, app_zq_req,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/mig7_arbiter.sv
// Two-requester arbiter sharing one MIG7 user interface in the ui_clk domain.
// Grants one requester for a burst of up to MAX_BURST commands, issues
// single-beat reads/writes, and steers read data back using a tag FIFO.
// Optional feature macro: MIG7_ARB_RR_EN (round-robin arbitration);
// without it requester 0 has fixed priority.
module mig7_arbiter #(
    parameter int AW        = 28,
    parameter int DW        = 128,
    parameter int MAX_BURST = 16,
    parameter int RD_DEPTH  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init_calib_complete,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_wr,
    input  logic [2*AW-1:0]     req_addr,
    input  logic [2*DW-1:0]     req_wdata,
    input  logic [2*DW/8-1:0]   req_wmask,
    output logic [1:0]          req_ready,
    output logic [1:0]          rd_valid,
    output logic [DW-1:0]       rd_data,
    output logic                rd_err,
    mig7_arbiter_if.master      ui
);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;

    typedef enum logic [1:0] {WAIT_CAL, ARB, BURST} state_t;

    state_t        state_reg;
    logic          grant_reg;
    logic [CW-1:0] cnt_reg;

    logic          tag_mem [RD_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   fifo_cnt_reg;
    logic          rd_err_reg;

    // Per-requester views of the packed request buses
    logic [AW-1:0]   addr_arr  [2];
    logic [DW-1:0]   wdata_arr [2];
    logic [DW/8-1:0] wmask_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*AW +: AW];
            assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
            assign wmask_arr[gi] = req_wmask[gi*(DW/8) +: DW/8];
        end
    endgenerate

    logic g_valid, g_wr, in_burst, issue_ok;
    logic fifo_full, fifo_empty, tag_out;
    logic pop, push, wr_issue, rd_issue, accept;
    logic pick, other;

    assign g_valid    = req_valid[grant_reg];
    assign g_wr       = req_wr[grant_reg];
    assign in_burst   = (state_reg == BURST);
    // A falling calibration flag blocks issue in the same cycle
    assign issue_ok   = in_burst & init_calib_complete & g_valid;
    assign fifo_full  = (fifo_cnt_reg == (PW+1)'(RD_DEPTH));
    assign fifo_empty = (fifo_cnt_reg == '0);
    assign tag_out    = tag_mem[rd_ptr_reg];
    assign pop        = ui.app_rd_data_valid & ~fifo_empty;

    // A read may still issue when full if a pop frees a slot in the same cycle
    assign wr_issue = issue_ok & g_wr & ui.app_rdy & ui.app_wdf_rdy;
    assign rd_issue = issue_ok & ~g_wr & (~fifo_full | pop);
    assign accept   = (wr_issue | rd_issue) & ui.app_rdy;
    assign push     = accept & ~g_wr;

    assign other = ~grant_reg;
`ifdef MIG7_ARB_RR_EN
    assign pick = req_valid[other] ? other : grant_reg;
`else
    assign pick = req_valid[0] ? 1'b0 : 1'b1;
`endif

    // MIG UI drive: request fields only while a grant is active, zero otherwise
    assign ui.app_en       = wr_issue | rd_issue;
    assign ui.app_cmd      = (in_burst && !g_wr) ? 3'b001 : 3'b000;
    assign ui.app_addr     = in_burst ? addr_arr[grant_reg]  : '0;
    assign ui.app_wdf_data = in_burst ? wdata_arr[grant_reg] : '0;
    assign ui.app_wdf_mask = in_burst ? wmask_arr[grant_reg] : '0;
    assign ui.app_wdf_wren = wr_issue;
    assign ui.app_wdf_end  = wr_issue;
    assign ui.app_sr_req   = 1'b0;
    assign ui.app_ref_req  = 1'b0;
    assign ui.app_zq_req   = 1'b0;

    assign req_ready = accept ? (grant_reg ? 2'b10 : 2'b01) : 2'b00;
    assign rd_valid  = pop ? (tag_out ? 2'b10 : 2'b01) : 2'b00;
    assign rd_data   = pop ? ui.app_rd_data : '0;
    assign rd_err    = rd_err_reg;

    // Arbitration FSM: calibration gate, grant selection, burst length limit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= WAIT_CAL;
            grant_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                WAIT_CAL: begin
                    if (init_calib_complete)
                        state_reg <= ARB;
                end
                ARB: begin
                    if (!init_calib_complete) begin
                        state_reg <= WAIT_CAL;
                    end else if (|req_valid) begin
                        grant_reg <= pick;
                        cnt_reg   <= '0;
                        state_reg <= BURST;
                    end
                end
                BURST: begin
                    if (!init_calib_complete) begin
                        state_reg <= WAIT_CAL;
                    end else if (!g_valid) begin
                        state_reg <= ARB;
                    end else if (accept) begin
                        if (cnt_reg == CW'(MAX_BURST - 1))
                            state_reg <= ARB;
                        else
                            cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= WAIT_CAL;
            endcase
        end
    end

    // Tag storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr_reg] <= grant_reg;
    end

    // Tag FIFO pointers, occupancy and sticky orphan-data flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
            rd_err_reg   <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
            if (ui.app_rd_data_valid && fifo_empty)
                rd_err_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mig7_arbiter.sv
// Directed bench for mig7_arbiter: cycle table for calibration gate, write
// handshake and read routing, then hand sequences for burst limit, tag FIFO
// full/bypass, orphan read data and reset during a burst.
module tb_mig7_arbiter;
    localparam int AW = 28;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int RD = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            calib;
    logic [1:0]      req_valid, req_wr, req_ready, rd_valid;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [2*DW/8-1:0] req_wmask;
    logic [DW-1:0]   rd_data;
    logic            rd_err;

    int n_cmp = 0;
    int n_err = 0;

    mig7_arbiter_if #(.AW(AW), .DW(DW)) ui ();

    mig7_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB), .RD_DEPTH(RD)) dut (
        .clk(clk), .rst(rst), .init_calib_complete(calib),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .ui(ui)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        calib;
        logic [1:0]  rv, wr;
        logic        rdy, wdf, dv;
        logic [31:0] rdata;
        logic        e_en, e_wren;
        logic [1:0]  e_ready;
        logic [2:0]  e_cmd;
        logic [27:0] e_addr;
        logic [1:0]  e_rdv;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(logic c, logic [1:0] rv, logic [1:0] wr,
                                logic rdy, logic wdf, logic dv, logic [31:0] rdata,
                                logic e_en, logic e_wren, logic [1:0] e_ready,
                                logic [2:0] e_cmd, logic [27:0] e_addr,
                                logic [1:0] e_rdv, logic [31:0] e_rdata);
        vec_t v;
        v.calib = c; v.rv = rv; v.wr = wr; v.rdy = rdy; v.wdf = wdf; v.dv = dv;
        v.rdata = rdata; v.e_en = e_en; v.e_wren = e_wren; v.e_ready = e_ready;
        v.e_cmd = e_cmd; v.e_addr = e_addr; v.e_rdv = e_rdv; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(logic c, logic [1:0] rv, logic [1:0] wr,
                          logic rdy, logic wdf, logic dv, logic [31:0] rdata);
        calib = c; req_valid = rv; req_wr = wr;
        ui.app_rdy = rdy; ui.app_wdf_rdy = wdf;
        ui.app_rd_data_valid = dv; ui.app_rd_data = rdata;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0);
        cyc(); cyc();
        rst = 1'b0;
    endtask

    vec_t tbl [19];
    logic [1:0] burst_exp [14];
    int acc, hits, stall_acc;

    initial begin
        req_addr  = {28'h0000200, 28'h0000100};
        req_wdata = {32'hB0B0_0002, 32'hA5A5_0001};
        req_wmask = {4'h0, 4'h3};
        rst = 1'b1;
        set_in(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0);

        // Reset state: every output low
        cyc(); cyc();
        chk("rst_app_en",   64'(ui.app_en), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_err",   64'(rd_err), 64'd0);
        chk("rst_app_cmd",  64'(ui.app_cmd), 64'd0);
        chk("rst_app_addr", 64'(ui.app_addr), 64'd0);
        chk("rst_wdf_data", 64'(ui.app_wdf_data), 64'd0);
        chk("rst_tied", 64'({ui.app_sr_req, ui.app_ref_req, ui.app_zq_req}), 64'd0);

        //             cal rv     wr     rdy  wdf  dv  rdata          en wren ready  cmd     addr       rdv    rdata
        tbl[0]  = mk(0, 2'b01, 2'b01, 1, 1, 0, 32'h0,          0, 0, 2'b00, 3'b000, 28'h0,   2'b00, 32'h0);
        tbl[1]  = mk(0, 2'b01, 2'b01, 1, 1, 0, 32'h0,          0, 0, 2'b00, 3'b000, 28'h0,   2'b00, 32'h0);
        tbl[2]  = mk(1, 2'b01, 2'b01, 1, 1, 0, 32'h0,          0, 0, 2'b00, 3'b000, 28'h0,   2'b00, 32'h0);
        tbl[3]  = mk(1, 2'b01, 2'b01, 1, 1, 0, 32'h0,          0, 0, 2'b00, 3'b000, 28'h0,   2'b00, 32'h0);
        tbl[4]  = mk(1, 2'b01, 2'b01, 1, 0, 0, 32'h0,          0, 0, 2'b00, 3'b000, 28'h100, 2'b00, 32'h0);
        tbl[5]  = mk(1, 2'b01, 2'b01, 1, 0, 0, 32'h0,          0, 0, 2'b00, 3'b000, 28'h100, 2'b00, 32'h0);
        tbl[6]  = mk(1, 2'b01, 2'b01, 1, 0, 0, 32'h0,          0, 0, 2'b00, 3'b000, 28'h100, 2'b00, 32'h0);
        tbl[7]  = mk(1, 2'b01, 2'b01, 1, 1, 0, 32'h0,          1, 1, 2'b01, 3'b000, 28'h100, 2'b00, 32'h0);
        tbl[8]  = mk(1, 2'b00, 2'b00, 1, 1, 0, 32'h0,          0, 0, 2'b00, 3'b001, 28'h100, 2'b00, 32'h0);
        tbl[9]  = mk(1, 2'b01, 2'b00, 1, 1, 0, 32'h0,          0, 0, 2'b00, 3'b000, 28'h0,   2'b00, 32'h0);
        tbl[10] = mk(1, 2'b11, 2'b00, 1, 1, 0, 32'h0,          1, 0, 2'b01, 3'b001, 28'h100, 2'b00, 32'h0);
        tbl[11] = mk(1, 2'b10, 2'b00, 1, 1, 0, 32'h0,          0, 0, 2'b00, 3'b001, 28'h100, 2'b00, 32'h0);
        tbl[12] = mk(1, 2'b10, 2'b00, 1, 1, 0, 32'h0,          0, 0, 2'b00, 3'b000, 28'h0,   2'b00, 32'h0);
        tbl[13] = mk(1, 2'b10, 2'b00, 0, 1, 0, 32'h0,          1, 0, 2'b00, 3'b001, 28'h200, 2'b00, 32'h0);
        tbl[14] = mk(1, 2'b10, 2'b00, 1, 1, 0, 32'h0,          1, 0, 2'b10, 3'b001, 28'h200, 2'b00, 32'h0);
        tbl[15] = mk(1, 2'b00, 2'b00, 1, 1, 0, 32'h0,          0, 0, 2'b00, 3'b001, 28'h200, 2'b00, 32'h0);
        tbl[16] = mk(1, 2'b00, 2'b00, 1, 1, 1, 32'hD1D1_0001,  0, 0, 2'b00, 3'b000, 28'h0,   2'b01, 32'hD1D1_0001);
        tbl[17] = mk(1, 2'b00, 2'b00, 1, 1, 1, 32'hD2D2_0002,  0, 0, 2'b00, 3'b000, 28'h0,   2'b10, 32'hD2D2_0002);
        tbl[18] = mk(1, 2'b00, 2'b00, 1, 1, 0, 32'h0000_0055,  0, 0, 2'b00, 3'b000, 28'h0,   2'b00, 32'h0);

        rst = 1'b0;
        for (int i = 0; i < 19; i++) begin
            set_in(tbl[i].calib, tbl[i].rv, tbl[i].wr, tbl[i].rdy, tbl[i].wdf,
                   tbl[i].dv, tbl[i].rdata);
            #1;
            $display("vec %0d: en=%b ready=%b cmd=%b addr=%h rd_valid=%b rd_data=%h",
                     i, ui.app_en, req_ready, ui.app_cmd, ui.app_addr, rd_valid, rd_data);
            chk($sformatf("v%0d_app_en", i),   64'(ui.app_en), 64'(tbl[i].e_en));
            chk($sformatf("v%0d_wdf_wren", i), 64'(ui.app_wdf_wren), 64'(tbl[i].e_wren));
            chk($sformatf("v%0d_wdf_end", i),  64'(ui.app_wdf_end), 64'(tbl[i].e_wren));
            chk($sformatf("v%0d_req_ready", i), 64'(req_ready), 64'(tbl[i].e_ready));
            chk($sformatf("v%0d_app_cmd", i),  64'(ui.app_cmd), 64'(tbl[i].e_cmd));
            chk($sformatf("v%0d_app_addr", i), 64'(ui.app_addr), 64'(tbl[i].e_addr));
            chk($sformatf("v%0d_rd_valid", i), 64'(rd_valid), 64'(tbl[i].e_rdv));
            chk($sformatf("v%0d_rd_data", i),  64'(rd_data), 64'(tbl[i].e_rdata));
            if (tbl[i].e_wren) begin
                chk($sformatf("v%0d_wdf_data", i), 64'(ui.app_wdf_data), 64'h0000_0000_A5A5_0001);
                chk($sformatf("v%0d_wdf_mask", i), 64'(ui.app_wdf_mask), 64'h3);
            end
            cyc();
        end
        chk("table_rd_err", 64'(rd_err), 64'd0);

        // Calibration loss mid-burst: nothing issues, back to WAIT_CAL
        set_in(1'b1, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0);   // ARB -> BURST
        cyc();                                                  // BURST: accept
        #1 chk("cal_burst_accept", 64'(req_ready), 64'b01);
        cyc();
        calib = 1'b0;
        #1 chk("cal_drop_en", 64'(ui.app_en), 64'd0);
        chk("cal_drop_ready", 64'(req_ready), 64'd0);
        cyc();
        calib = 1'b1;
        #1 chk("cal_wait_en", 64'(ui.app_en), 64'd0);            // WAIT_CAL
        cyc();
        #1 chk("cal_arb_en", 64'(ui.app_en), 64'd0);             // ARB
        cyc();
        #1 chk("cal_resume", 64'(req_ready), 64'b01);            // BURST again
        $display("seq calib_drop done");

        // Burst limit with both requesters writing continuously
`ifdef MIG7_ARB_RR_EN
        burst_exp = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
                      2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
`else
        burst_exp = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                      2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01};
`endif
        do_reset();
        set_in(1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int c = 0; c < 14; c++) begin
            #1;
            $display("burst cycle %0d: ready=%b", c, req_ready);
            chk($sformatf("burst_c%0d", c), 64'(req_ready), 64'(burst_exp[c]));
            cyc();
        end

        // Tag FIFO fill: 32 reads with no return, then the 33rd stalls
        do_reset();
        set_in(1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0);
        acc = 0;
        for (int c = 0; c < 200 && acc < RD; c++) begin
            #1;
            if (req_ready[0]) acc++;
            cyc();
        end
        chk("fifo_fill_count", 64'(acc), 64'(RD));
        stall_acc = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (ui.app_en || req_ready != 2'b00) stall_acc++;
            cyc();
        end
        chk("fifo_full_stall", 64'(stall_acc), 64'd0);
        // Pop and push in the same cycle while full
        ui.app_rd_data_valid = 1'b1;
        ui.app_rd_data = 32'hCAFE_0001;
        #1;
        $display("fifo bypass: en=%b ready=%b rd_valid=%b", ui.app_en, req_ready, rd_valid);
        chk("fifo_bypass_en", 64'(ui.app_en), 64'd1);
        chk("fifo_bypass_ready", 64'(req_ready), 64'b01);
        chk("fifo_bypass_rdv", 64'(rd_valid), 64'b01);
        chk("fifo_bypass_data", 64'(rd_data), 64'hCAFE_0001);
        cyc();
        ui.app_rd_data_valid = 1'b0;
        #1 chk("fifo_still_full", 64'(ui.app_en), 64'd0);
        cyc();
        // Drain: exactly 32 tags remain, all for requester 0
        req_valid = 2'b00;
        ui.app_rd_data_valid = 1'b1;
        hits = 0;
        for (int c = 0; c < RD; c++) begin
            #1;
            if (rd_valid == 2'b01) hits++;
            cyc();
        end
        chk("fifo_drain_hits", 64'(hits), 64'(RD));
        chk("drain_rd_err", 64'(rd_err), 64'd0);

        // Orphan read data: no rd_valid, sticky error
        #1 chk("orphan_rd_valid", 64'(rd_valid), 64'd0);
        cyc();
        ui.app_rd_data_valid = 1'b0;
        #1 chk("orphan_rd_err", 64'(rd_err), 64'd1);
        cyc(); cyc();
        #1 chk("orphan_rd_err_sticky", 64'(rd_err), 64'd1);
        $display("seq orphan done: rd_err=%b", rd_err);

        // Reset mid-burst with a read outstanding
        req_valid = 2'b01;
        acc = 0;
        for (int c = 0; c < 10 && acc == 0; c++) begin
            #1;
            if (req_ready[0]) acc++;
            cyc();
        end
        chk("rstmid_accept", 64'(acc), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rstmid_app_en", 64'(ui.app_en), 64'd0);
        chk("rstmid_ready", 64'(req_ready), 64'd0);
        chk("rstmid_cmd_addr", 64'({ui.app_cmd, ui.app_addr}), 64'd0);
        chk("rstmid_rd_err", 64'(rd_err), 64'd0);
        cyc();
        req_valid = 2'b00;
        ui.app_rd_data_valid = 1'b1;
        #1 chk("rstmid_late_rdv", 64'(rd_valid), 64'd0);
        cyc();
        ui.app_rd_data_valid = 1'b0;
        #1 chk("rstmid_late_err", 64'(rd_err), 64'd1);
        $display("seq reset_mid_burst done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
